// File: rtl/solver_pkg.sv
// solver_pkg: shared widths, saturation limits and the divider state type.
package solver_pkg;
    localparam int A_W   = 16;
    localparam int X_W   = 32;
    localparam int SHIFT = 2;
    localparam int D_W   = X_W - SHIFT;
    localparam int CNT_W = $clog2(D_W);
    localparam logic [A_W-1:0] Q16_POS_MAX = 16'h7FFF;
    localparam logic [A_W-1:0] Q16_NEG_MAX = 16'h8000;
    localparam logic [X_W-1:0] POS_MAX = 32'h7FFF_FFFF;
    localparam logic [X_W-1:0] NEG_MAX = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/div_xa_seq_if.sv
// div_xa_seq_if: operand/result valid-ready bundle of the back-path divider.
interface div_xa_seq_if;
    import solver_pkg::*;
    logic           in_valid;
    logic           in_ready;
    logic [X_W-1:0] x;
    logic [A_W-1:0] a;
    logic           out_valid;
    logic           out_ready;
    logic [A_W-1:0] q;
    logic           sat;
    logic           div_zero;
    modport master (output in_valid, x, a, out_ready,
                    input  in_ready, out_valid, q, sat, div_zero);
    modport slave  (input  in_valid, x, a, out_ready,
                    output in_ready, out_valid, q, sat, div_zero);
endinterface

// File: rtl/div_xa_seq_step.sv
// div_step: one restoring-division iteration on unsigned magnitudes.
module div_step
    import solver_pkg::*;
(
    input  logic [A_W:0] rem_in,
    input  logic         bit_in,
    input  logic [A_W:0] divisor,
    output logic [A_W:0] rem_out,
    output logic         q_bit
);
    logic [A_W+1:0] t;
    assign t       = {rem_in, bit_in};
    assign q_bit   = t >= {1'b0, divisor};
    assign rem_out = q_bit ? (A_W+1)'(t - {1'b0, divisor}) : t[A_W:0];
endmodule

// File: rtl/div_xa_seq.sv
// div_xa_seq: sequential signed divider b = sat16(trunc((x >>> 2) / a)), one quotient bit per cycle.
module div_xa_seq
    import solver_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    div_xa_seq_if.slave bus
);
    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt;
    logic [D_W-1:0]        dvd;
    logic [D_W-2:0]        qm;
    logic [A_W:0]          rem, a_mag, rem_nx, a_ext, a_mag_in;
    logic                  neg, q_bit, accept, last, sat_fin;
    logic [A_W-1:0]        q_r, q_fin;
    logic                  sat_r, dz_r;
    logic signed [D_W-1:0] d;
    logic [D_W-1:0]        d_mag, qm_f;
    assign d        = bus.x[X_W-1:SHIFT];
    assign d_mag    = d[D_W-1] ? D_W'(-d) : d;
    // sign-extend before negating so a = -32768 yields magnitude 32768
    assign a_ext    = {bus.a[A_W-1], bus.a};
    assign a_mag_in = a_ext[A_W] ? -a_ext : a_ext;
    assign accept   = state == IDLE && bus.in_valid;
    assign last     = state == BUSY && cnt == '0;
    div_step u_step (
        .rem_in  (rem),
        .bit_in  (dvd[D_W-1]),
        .divisor (a_mag),
        .rem_out (rem_nx),
        .q_bit   (q_bit)
    );
    assign qm_f    = {qm, q_bit};
    assign sat_fin = neg ? qm_f > D_W'(Q16_NEG_MAX) : qm_f > D_W'(Q16_POS_MAX);
    assign q_fin   = sat_fin ? (neg ? Q16_NEG_MAX : Q16_POS_MAX)
                             : (neg ? A_W'(-qm_f[A_W-1:0]) : qm_f[A_W-1:0]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx      = state;
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
        if (accept) state_nx = bus.a == '0 ? DONE : BUSY;
        if (last) state_nx = DONE;
        if (state == DONE && bus.out_ready) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            dvd   <= '0;
            qm    <= '0;
            rem   <= '0;
            a_mag <= '0;
            neg   <= 1'b0;
            q_r   <= '0;
            sat_r <= 1'b0;
            dz_r  <= 1'b0;
        end else begin
            if (accept) begin
                dvd   <= d_mag;
                qm    <= '0;
                rem   <= '0;
                a_mag <= a_mag_in;
                neg   <= d[D_W-1] ^ bus.a[A_W-1];
                cnt   <= CNT_W'(D_W - 1);
                if (bus.a == '0) begin
                    q_r   <= d[D_W-1] ? Q16_NEG_MAX : Q16_POS_MAX;
                    sat_r <= 1'b1;
                    dz_r  <= 1'b1;
                end
            end
            if (state == BUSY) begin
                dvd <= {dvd[D_W-2:0], 1'b0};
                rem <= rem_nx;
                qm  <= qm_f[D_W-2:0];
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    q_r   <= q_fin;
                    sat_r <= sat_fin;
                    dz_r  <= 1'b0;
                end
            end
        end
    end
    assign bus.q        = q_r;
    assign bus.sat      = sat_r;
    assign bus.div_zero = dz_r;
endmodule

// File: tb/tb_div_xa_seq.sv
// tb_div_xa_seq: randomized and directed checks of div_xa_seq against an integer-arithmetic model.
module tb_div_xa_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [17:0] exp_q[$];

    div_xa_seq_if bus();
    div_xa_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // plain signed integer division, truncating toward zero, then clamp
    function automatic void model(input logic [31:0] xv, input logic [15:0] av,
                                  output logic [15:0] qv, output logic sv, output logic zv);
        longint d  = longint'($signed(xv)) >>> 2;
        longint ai = longint'($signed(av));
        longint r;
        if (av == 16'h0) begin
            zv = 1'b1;
            sv = 1'b1;
            qv = d >= 0 ? 16'h7FFF : 16'h8000;
        end else begin
            r  = d / ai;
            zv = 1'b0;
            sv = r > 32767 || r < -32768;
            qv = r > 32767 ? 16'h7FFF : r < -32768 ? 16'h8000 : r[15:0];
        end
    endfunction

    always begin
        @(negedge clk);
        #2;
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                chk("result", {14'd0, bus.q, bus.sat, bus.div_zero}, {14'd0, exp_q[0]});
                chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic op(input logic [31:0] xv, input logic [15:0] av, input bit use_lit,
                      input logic [15:0] lq, input bit ls, input bit lz,
                      input int hold, input bit rdy_hi, input bit noise);
        logic [15:0] mq;
        logic        ms, mz;
        int          n;
        model(xv, av, mq, ms, mz);
        if (use_lit) begin
            chk("model_pin", {14'd0, mq, ms, mz}, {14'd0, lq, ls, lz});
            mq = lq;
            ms = ls;
            mz = lz;
        end
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.x         = xv;
        bus.a         = av;
        bus.in_valid  = 1'b1;
        bus.out_ready = rdy_hi;
        exp_q.push_back({mq, ms, mz});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.x        = $urandom;
        bus.a        = 16'($urandom);
        n = 1;
        while (!bus.out_valid && n < 100) begin
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.x        = $urandom;
                bus.a        = 16'($urandom);
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("latency", 32'(n), av == 16'h0 ? 32'd1 : 32'd31);
        if (!rdy_hi) begin
            repeat (hold) @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] av, bv;
        logic [31:0] xv;
        longint      p;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = '0;
        bus.a         = '0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_q_sat_dz", {14'd0, bus.q, bus.sat, bus.div_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op(32'h0000_0018, 16'd3,     1, 16'd2,    1'b0, 1'b0, 0, 0, 0);
        op(32'hFFFF_FFE4, 16'd2,     1, 16'hFFFD, 1'b0, 1'b0, 0, 0, 0);
        op(32'hFFFF_FFE4, 16'hFFFE,  1, 16'd3,    1'b0, 1'b0, 0, 0, 0);
        op(32'h7FFF_FFFF, 16'd1,     1, 16'h7FFF, 1'b1, 1'b0, 0, 0, 0);
        op(32'h8000_0000, 16'hFFFF,  1, 16'h7FFF, 1'b1, 1'b0, 0, 0, 0);
        op(32'h8000_0000, 16'd1,     1, 16'h8000, 1'b1, 1'b0, 0, 0, 0);
        op(32'h8000_0000, 16'd0,     1, 16'h8000, 1'b1, 1'b1, 0, 0, 0);
        op(32'h0000_0000, 16'd0,     1, 16'h7FFF, 1'b1, 1'b1, 0, 0, 0);
        op(32'h0000_0003, 16'h8000,  1, 16'd0,    1'b0, 1'b0, 0, 0, 0);
        op(32'h0048_D000, 16'h0100,  1, 16'h1234, 1'b0, 1'b0, 0, 0, 0);
        op(32'd400,       16'd7,     1, 16'd14,   1'b0, 1'b0, 5, 0, 0);
        op(32'hFFFF_F000, 16'd10,    1, 16'hFF9A, 1'b0, 1'b0, 0, 1, 1);

        // abort an operation mid-flight; nothing may come out of it
        @(negedge clk);
        bus.x        = 32'h0123_4567;
        bus.a        = 16'd5;
        bus.in_valid = 1'b1;
        exp_q.push_back(18'h0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_q", {14'd0, bus.q, bus.sat, bus.div_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        op(32'h0000_0018, 16'd3, 1, 16'd2, 1'b0, 1'b0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            xv = $urandom;
            case ($urandom_range(0, 3))
                0:       av = 16'h0;
                1:       av = 16'($urandom_range(1, 40));
                2:       av = -16'($urandom_range(1, 40));
                default: av = 16'($urandom);
            endcase
            op(xv, av, 0, 16'h0, 1'b0, 1'b0, int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 20; i++) begin
            av = 16'($urandom);
            if (av == 16'h0) av = 16'h1;
            bv = i < 10 ? 16'($urandom_range(0, 255)) - 16'd128 : 16'($urandom);
            p  = longint'($signed(av)) * longint'($signed(bv)) * 4;
            if (p > 64'sd2147483647)       xv = 32'h7FFF_FFFF;
            else if (p < -64'sd2147483648) xv = 32'h8000_0000;
            else                           xv = p[31:0];
            op(xv, av, xv == 32'(p), bv, 1'b0, 1'b0, 0, 0, 0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/div_xa_seq.md
Name: div_xa_seq

Overview:
- Sequential signed divider. It is the inverse of the saturating multiplier that forms x = sat(a*b << 2).
- Given the 32-bit scaled result x and the 16-bit diagonal coefficient a, it recovers b = trunc((x >>> 2) / a), saturated to 16 bits.
- Used in the solver back-path to undo the diagonal scaling.
- Valid/ready on both sides; radix-2 restoring division, one quotient bit per cycle.

Parameters:
- A_W, 16: width of divisor a and of quotient q (two's complement).
- X_W, 32: width of dividend x (two's complement).
- SHIFT, 2: arithmetic right shift applied to x before division; mirrors the multiplier's left shift.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  x/a operands valid.
- in_ready  out  1  block idle, can accept.
- x  in  X_W  signed dividend.
- a  in  A_W  signed divisor.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- q  out  A_W  signed quotient, saturated.
- sat  out  1  quotient clipped to 16-bit range (includes div-by-zero).
- div_zero  out  1  a == 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, q=0, sat=0, div_zero=0.
  - Counter and datapath registers cleared.
  - Reset in any state aborts the operation in flight; no output is produced.
- Arithmetic:
  - D = x >>> SHIFT, a 30-bit signed value.
  - Divide |D| (30 b) by |a| (16 b) into a 30-bit magnitude quotient Qm; the remainder is discarded.
  - Result sign = sign(D) XOR sign(a); negate Qm when the sign is negative (truncation toward zero).
  - Saturate the signed result to [-32768, 32767]; sat=1 when clipped.
  - |a| for a = -32768 is 32768; use a 17-bit magnitude register.
- State IDLE:
  - in_ready=1.
  - On in_valid && in_ready, latch |D|, |a|, neg, and set cnt=29.
  - If a == 0, go to DONE instead, with div_zero=1, sat=1, q = 32767 if D >= 0 else -32768.
  - Otherwise go to BUSY.
- State BUSY:
  - in_ready=0.
  - Each cycle: rem = {rem, next dividend bit}; if rem >= |a|, subtract and shift in quotient bit 1, else shift in 0; cnt--.
  - On the cycle cnt == 0, register the signed, saturated q, sat and div_zero=0, then go to DONE.
  - Exactly 30 BUSY cycles.
- State DONE:
  - out_valid=1; q/sat/div_zero stable.
  - On out_ready, go to IDLE and drop out_valid on the next edge.
- Latency:
  - Normal operands: out_valid rises 31 edges after the accept edge, i.e. after 1 accept edge + 30 BUSY edges.
  - a == 0: out_valid rises 1 edge after the accept edge.
- Handshake:
  - No new input accepted until the result has handed off; in_ready is low in BUSY and DONE.
  - in_ready does not depend combinationally on out_ready; throughput is one result per ≥32 cycles.
  - in_valid while busy is ignored; the source must hold x/a until in_ready.
- Boundaries:
  - D = -2^29, a = -1: Qm = 2^29, sat → 32767, sat=1.
  - D = 0: q=0, sat=0 (any nonzero a).
  - out_ready held high in DONE: one-cycle out_valid pulse.
  - x low 2 bits are ignored by design.

Decomposition:
- Shared package (solver_pkg) holds:
  - A_W, X_W, SHIFT.
  - Q16_POS_MAX = 16'h7FFF and Q16_NEG_MAX = 16'h8000.
  - The existing 32-bit POS_MAX/NEG_MAX.
  - State enum {IDLE, BUSY, DONE}.
- One natural combinational sub-module, div_step: a single restoring iteration (rem_in, dividend bit, divisor → rem_out, q_bit), instantiated once in the top FSM.

Test Plan:
1. x=32'h0000_0018, a=3, after reset → q=2, sat=0, div_zero=0; out_valid exactly 31 edges after accept.
2. x=32'hFFFF_FFE4 (D=-7), a=2 → q=-3 (16'hFFFD), sat=0; a=-2 → q=3.
3. x=32'h7FFF_FFFF, a=1 → q=16'h7FFF, sat=1. x=32'h8000_0000, a=-1 → q=16'h7FFF, sat=1. x=32'h8000_0000, a=1 → q=16'h8000, sat=1.
4. a=0, x=32'h8000_0000 → q=16'h8000, div_zero=1, sat=1, out_valid 1 edge after accept. a=0, x=0 → q=16'h7FFF.
5. Round trip: a=16'h0100, b=16'h1234 through the multiplier gives x=32'h0048_D000 → q=16'h1234, sat=0; random a≠0, b within non-saturating range → q==b.
6. Protocol:
   - Hold out_ready=0 for 5 cycles in DONE → q stable, in_ready=0.
   - in_valid pulses during BUSY are ignored.
   - Assert rst_n=0 at BUSY cycle 10 → immediate IDLE, out_valid=0, no result; the next operation is correct.
